// File: rtl/tile_lane_sequencer.sv
// tile_lane_sequencer: LANES x DEPTH falling-tile grid with tick pacing, LFSR spawn, hit judging and score.
// Define TILE_AUTOPLAY_EN for demo mode, where the bottom row is auto-hit on every tick.
module tile_lane_sequencer #(
    parameter int         LANES    = 4,
    parameter int         DEPTH    = 10,
    parameter int         TICK_DIV = 25000000,
    parameter int         IDX_W    = 8,
    parameter logic [7:0] SEED     = 8'hA5
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [LANES-1:0]       hit,
    input  logic [1:0]             speed,
    output logic [LANES*DEPTH-1:0] grid,
    output logic                   t,
    output logic [IDX_W-1:0]       index,
    output logic [7:0]             score,
    output logic [1:0]             state,
    output logic                   miss
);
    localparam int GW  = LANES * DEPTH;
    localparam int BOT = (DEPTH - 1) * LANES;
    localparam int CW  = (TICK_DIV < 3) ? 2 : $clog2(TICK_DIV + 1);

    localparam logic [CW-1:0]    TICK_C  = TICK_DIV[CW-1:0];
    localparam logic [CW-1:0]    CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [LANES-1:0] LANE_ONE = {{(LANES-1){1'b0}}, 1'b1};
    localparam logic [7:0]       LANES_B = LANES[7:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    grid_q, grid_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [7:0]       score_q, score_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    per_q, per_d;
    logic             t_q, t_d;
    logic             miss_q, miss_d;

    logic [CW-1:0]    per_sel;
    logic [LANES-1:0] bottom;
    logic [LANES-1:0] left;
    logic [LANES-1:0] new_row;
    logic [7:0]       lane_mod;
    logic             tick_cond;
    logic             end_game;

    function automatic logic [3:0] popcnt(input logic [LANES-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < LANES; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {5'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Period of zero (large speed shift) still has to produce a tick.
    always_comb begin
        per_sel = TICK_C >> speed;
        if (per_sel == '0) begin
            per_sel = CNT_ONE;
        end
    end

`ifdef TILE_AUTOPLAY_EN
    logic unused_hit;
    assign unused_hit = ^hit;
`endif

    always_comb begin
        state_d   = state_q;
        grid_d    = grid_q;
        index_d   = index_q;
        score_d   = score_q;
        lfsr_d    = lfsr_q;
        cnt_d     = '0;
        per_d     = per_q;
        t_d       = 1'b0;
        miss_d    = 1'b0;
        bottom    = grid_q[BOT +: LANES];
        left      = bottom;
        new_row   = '0;
        lane_mod  = lfsr_q % LANES_B;
        tick_cond = (cnt_q == per_q - CNT_ONE);
        end_game  = 1'b0;

        unique case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d = RUN;
                    grid_d  = '0;
                    index_d = '0;
                    score_d = '0;
                    per_d   = per_sel;
                end
            end
            RUN: begin
`ifdef TILE_AUTOPLAY_EN
                if (t_q) begin
                    score_d = sat_add(score_q, popcnt(bottom));
                    left    = '0;
                end
`else
                if (hit != '0) begin
                    if ((hit & ~bottom) != '0) begin
                        end_game = 1'b1;
                    end else begin
                        score_d = sat_add(score_q, popcnt(hit));
                        left    = bottom & ~hit;
                    end
                end
`endif
                grid_d[BOT +: LANES] = left;
                // Hits land first, so only tiles still present escape.
                if (!end_game && t_q) begin
                    if (left != '0) begin
                        end_game = 1'b1;
                    end else begin
                        if (!index_q[0]) begin
                            new_row = LANE_ONE << lane_mod[2:0];
                        end
                        grid_d  = {grid_q[BOT-1:0], new_row};
                        index_d = index_q + IDX_ONE;
                        lfsr_d  = {lfsr_q[6:0],
                                   lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                    end
                end
                if (end_game) begin
                    state_d = OVER;
                    miss_d  = 1'b1;
                end else if (tick_cond) begin
                    t_d   = 1'b1;
                    per_d = per_sel;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q <= IDLE;
            grid_q  <= '0;
            index_q <= '0;
            score_q <= '0;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            per_q   <= TICK_C;
            t_q     <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grid_q  <= grid_d;
            index_q <= index_d;
            score_q <= score_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            t_q     <= t_d;
            miss_q  <= miss_d;
        end
    end

    assign grid  = grid_q;
    assign t     = t_q;
    assign index = index_q;
    assign score = score_q;
    assign state = state_q;
    assign miss  = miss_q;

endmodule

// File: tb/tb_tile_lane_sequencer.sv
// Scoreboard bench for tile_lane_sequencer: a game-level model predicts every
// registered output per cycle; a negedge monitor pops and compares.
module tb_tile_lane_sequencer;
    localparam int LANES    = 4;
    localparam int DEPTH    = 4;
    localparam int TICK_DIV = 8;
    localparam int IDX_W    = 8;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic                   start;
    logic [LANES-1:0]       hit;
    logic [1:0]             speed;
    logic [LANES*DEPTH-1:0] grid;
    logic                   t;
    logic [IDX_W-1:0]       index;
    logic [7:0]             score;
    logic [1:0]             state;
    logic                   miss;

    tile_lane_sequencer #(
        .LANES(LANES), .DEPTH(DEPTH), .TICK_DIV(TICK_DIV),
        .IDX_W(IDX_W), .SEED(8'hA5)
    ) dut (
        .CLOCK_50(clk), .resetn(resetn), .start(start), .hit(hit),
        .speed(speed), .grid(grid), .t(t), .index(index),
        .score(score), .state(state), .miss(miss)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                     tag;
        logic [LANES*DEPTH-1:0] grid;
        logic                   t;
        logic [7:0]             idx;
        logic [7:0]             score;
        logic [1:0]             st;
        logic                   miss;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Game model: lane bitmask per row, countdown to the next visible t pulse.
    int               m_st;
    logic [LANES-1:0] m_row [DEPTH];
    int               m_score;
    int               m_idx;
    int               m_wait;
    logic [7:0]       m_lfsr;
    bit               m_t;
    bit               m_miss;

    function automatic int period(input logic [1:0] sp);
        int p;
        p = TICK_DIV >> sp;
        return (p == 0) ? 1 : p;
    endfunction

    task automatic model_step(input bit rst, input bit go,
                              input logic [LANES-1:0] h, input logic [1:0] sp);
        bit               over;
        logic [LANES-1:0] bot;
        if (!rst) begin
            m_st = 0;
            for (int r = 0; r < DEPTH; r++) m_row[r] = '0;
            m_score = 0; m_idx = 0; m_wait = 0;
            m_lfsr = 8'hA5; m_t = 0; m_miss = 0;
            return;
        end
        if (m_st != 1) begin
            m_t = 0; m_miss = 0;
            if (go) begin
                m_st = 1;
                for (int r = 0; r < DEPTH; r++) m_row[r] = '0;
                m_idx = 0; m_score = 0;
                m_wait = period(sp);
            end
            return;
        end
        over = 0;
        bot  = m_row[DEPTH-1];
`ifdef TILE_AUTOPLAY_EN
        if (m_t) begin
            m_score = m_score + $countones(bot);
            if (m_score > 255) m_score = 255;
            m_row[DEPTH-1] = '0;
        end
`else
        if (h != '0) begin
            if ((h & ~bot) != '0) over = 1;
            else begin
                m_score = m_score + $countones(h);
                if (m_score > 255) m_score = 255;
                m_row[DEPTH-1] = bot & ~h;
            end
        end
`endif
        if (!over && m_t) begin
            if (m_row[DEPTH-1] != '0) over = 1;
            else begin
                for (int r = DEPTH - 1; r > 0; r--) m_row[r] = m_row[r-1];
                m_row[0] = '0;
                if (m_idx % 2 == 0) m_row[0][m_lfsr % LANES] = 1'b1;
                m_idx  = (m_idx + 1) % 256;
                m_lfsr = {m_lfsr[6:0], 1'($countones(m_lfsr & 8'hB8) % 2)};
            end
        end
        if (over) begin
            m_st = 2; m_miss = 1; m_t = 0;
        end else begin
            m_miss = 0;
            m_wait = m_wait - 1;
            if (m_wait == 0) begin
                m_t = 1;
                m_wait = period(sp);
            end else begin
                m_t = 0;
            end
        end
    endtask

    task automatic step(input bit rst, input bit go,
                        input logic [LANES-1:0] h, input logic [1:0] sp);
        exp_t e;
        resetn = rst; start = go; hit = h; speed = sp;
        model_step(rst, go, h, sp);
        e.tag = cyc + 1;
        for (int r = 0; r < DEPTH; r++) e.grid[r*LANES +: LANES] = m_row[r];
        e.t     = m_t;
        e.idx   = 8'(m_idx);
        e.score = 8'(m_score);
        e.st    = 2'(m_st);
        e.miss  = m_miss;
        q.push_back(e);
        @(negedge clk);
    endtask

    // Perfect player: presses the bottom tile sometimes, always on a tick.
    function automatic logic [LANES-1:0] play();
        logic [LANES-1:0] b;
        b = m_row[DEPTH-1];
        if (b != '0 && (m_t || $urandom_range(0, 2) == 0)) return b;
        return '0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].tag <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.tag < cyc) begin
                checks++; errors++;
                $display("FAIL stale cyc=%0d got=%0d exp=%0d", cyc, cyc, e.tag);
            end else begin
                chk("grid",  32'(grid),  32'(e.grid));
                chk("t",     32'(t),     32'(e.t));
                chk("index", 32'(index), 32'(e.idx));
                chk("score", 32'(score), 32'(e.score));
                chk("state", 32'(state), 32'(e.st));
                chk("miss",  32'(miss),  32'(e.miss));
            end
        end
    end

    task automatic bound_fail(input string name);
        checks++; errors++;
        $display("FAIL %s got=timeout exp=event", name);
    endtask

    initial begin
        int n;
        resetn = 1'b0; start = 1'b0; hit = '0; speed = 2'd0;
        step(0, 0, '0, 0);
        step(0, 0, '0, 0);
        step(1, 0, 4'hF, 0);
        step(1, 1, '0, 0);
        for (int i = 0; i < 27; i++) step(1, 0, '0, 0);
        for (int i = 0; i < 12; i++) step(1, 0, play(), 2);
        for (int i = 0; i < 1200; i++) begin
            step(1, (i == 50), play(), (i < 100) ? 2'd1 : (i < 200) ? 2'd2 : 2'd3);
        end
`ifndef TILE_AUTOPLAY_EN
        n = 0;
        while (m_row[DEPTH-1] != '0 && n < 50) begin
            step(1, 0, m_row[DEPTH-1], 1);
            n++;
        end
        if (n == 50) bound_fail("wrong_hit_wait");
        step(1, 0, 4'b0001, 1);
        for (int i = 0; i < 20; i++) step(1, 0, 4'($urandom_range(0, 15)), 1);
        step(1, 1, '0, 2);
        n = 0;
        while (m_st == 1 && n < 200) begin
            step(1, 0, '0, 2);
            n++;
        end
        if (n == 200) bound_fail("escape_wait");
        for (int i = 0; i < 4; i++) step(1, 0, '0, 2);
        step(1, 1, '0, 2);
`endif
        for (int i = 0; i < 30; i++) step(1, 0, play(), 1);
        step(0, 0, play(), 1);
        step(0, 1, 4'hF, 1);
        step(1, 1, '0, 1);
        for (int i = 0; i < 60; i++) step(1, 0, play(), 1);
        for (int i = 0; i < 1500; i++) begin
            logic [LANES-1:0] h;
            h = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : play();
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 39) == 0),
                 h, 2'(($urandom_range(0, 3) + i / 400) % 4));
        end
        step(1, 0, '0, 0);
        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tile_lane_sequencer.md
Name: tile_lane_sequencer

Overview:
- Parametrised successor to the single-strip LED tile driver used in the piano-tiles game.
- Generates a LANES x DEPTH grid of falling tiles. Paces tile steps with a programmable tick divider and draws new tiles from an LFSR.
- Judges player hits against the bottom row and keeps score.
- Sits between the board I/O (KEY/SW edge-detected upstream) and the display/LED drivers in top.

Parameters:
- LANES, 4, number of tile lanes (legal 2..8).
- DEPTH, 10, rows per lane; row 0 is the top, row DEPTH-1 the hit row.
- TICK_DIV, 25000000, CLOCK_50 cycles per step at speed 0.
- IDX_W, 8, width of the step index counter.
- SEED, 8'hA5, LFSR reset value; must be non-zero.

Ports:
- CLOCK_50 input 1: 50 MHz clock; all logic is rising-edge.
- resetn input 1: synchronous active-low reset.
- start input 1: one-cycle pulse; starts or restarts a game.
- hit input LANES: one-cycle press pulses, one bit per lane, already synchronised and edge-detected.
- speed input 2: step period = TICK_DIV >> speed; sampled at each tick.
- grid output LANES*DEPTH: bit [r*LANES+l] is the tile at row r, lane l.
- t output 1: one-cycle step pulse.
- index output IDX_W: step count.
- score output 8: correct hits.
- state output 2: 0 IDLE, 1 RUN, 2 OVER.
- miss output 1: one-cycle pulse on the game-ending event.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - grid, t, index, score, miss, and the divider are all 0.
  - state = IDLE.
  - LFSR = SEED.
  - Reset overrides every other input in the same cycle, including mid-game.
- Divider:
  - Counts only in RUN.
  - t=1 for exactly one cycle when cnt = (TICK_DIV>>speed)-1, then cnt returns to 0.
  - A period of 0 is treated as 1.
  - The divider is held at 0 outside RUN.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Advances once per tick.
  - New lane = lfsr % LANES, using the pre-advance value.
- Tick (t=1):
  - Every row shifts down: row r <= row r-1.
  - Row 0 <= one-hot(new lane) when index[0]=0. Row 0 <= 0 when index[0]=1, which leaves a gap row.
  - index increments and wraps modulo 2^IDX_W.
- Escape: if the bottom row is non-zero at a tick, after applying same-cycle hits, then miss pulses and state goes to OVER. The grid is frozen without shifting.
- Hit evaluation, RUN only, against the bottom row as registered before this cycle's tick:
  - All pressed bits set in the bottom row: those bits clear, and score += popcount(pressed). Score saturates at 255.
  - Any pressed bit not set: miss pulses, state goes to OVER, score is unchanged and the grid freezes.
  - Hit and tick in the same cycle: hits are applied first. A tile that was cleared by the hit is not an escape.
- Hits in IDLE or OVER are ignored.
- FSM transitions:
  - IDLE --start--> RUN: grid and index clear, score clears.
  - RUN --miss--> OVER.
  - OVER --start--> RUN: grid, index and score clear; the LFSR is not reseeded.
  - start in RUN is ignored.
- Output timing:
  - All outputs are registered.
  - The grid update is visible the cycle after t.
  - score, state and miss reflect a hit one cycle after the hit pulse.

Optional Feature:
- Macro: TILE_AUTOPLAY_EN.
- Defined:
  - Demo mode: on every tick the bottom row is treated as fully hit before the escape check. score += popcount(bottom row).
  - The hit input is ignored, so the game never reaches OVER.
- Undefined: the hit port is judged as specified in Behaviour; no autoplay logic is generated.

Test Plan:
- Reset behaviour: TICK_DIV=4, resetn low for 2 cycles mid-RUN -> grid=0, score=0, index=0, state=0, t=0, and the LFSR sequence restarts from 8'hA5.
- Start and tick pacing:
  - TICK_DIV=8, speed=0, start pulse -> state=1, t every 8 cycles; after 3 ticks index=3.
  - Grid has non-zero rows 0 and 2 and zero row 1.
  - speed=2 -> t every 2 cycles.
- Correct hit: TICK_DIV=4, DEPTH=4; pulse hit on exactly the lane set in the bottom row -> that bit clears, score=1, no miss, state stays 1.
- Wrong hit: hit on an empty bottom-row lane -> miss=1 for 1 cycle, state=2, score unchanged, grid frozen for 20 cycles.
- Escape:
  - No hits for DEPTH+1 ticks -> miss when the first tile leaves, state=2.
  - A following start -> state=1, score=0, grid=0.
- Simultaneous hit and tick: the correct hit arrives on the tick cycle with the tile in the bottom row -> score +1, no escape miss. With TILE_AUTOPLAY_EN, 50 ticks pass with no OVER and score = number of tiles reaching the bottom.
